// File: rtl/dcl_mab_pkg.sv
// Shared types and helpers for the multi-input arbiter slice: sink FSM states,
// default widths, the packet struct and a width-generic saturating add.
package dcl_mab_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_TS_W   = 16;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 32;
    localparam int SAT_W      = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } sink_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] dst;
        logic [DEF_TS_W-1:0]   ts;
        logic [DEF_DATA_W-1:0] data;
    } pkt_t;

    // Adds two unsigned values and clamps the result to the all-ones value of a w-bit counter.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int unsigned      w);
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        logic [SAT_W:0] one;
        one    = '0;
        one[0] = 1'b1;
        sum    = {1'b0, a} + {1'b0, b};
        lim    = (one << w) - one;
        return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/dcl_pat_rotator.sv
// 16-bit backpressure pattern register: load (zero replaced by 16'h0001),
// rotate left by one, or hold. Bit 0 is the ready candidate for the current cycle.
module dcl_pat_rotator (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        rotate,
    input  logic [15:0] load_val,
    output logic        pat0
);

    logic [15:0] pat;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pat <= 16'h0001;
        end else if (load) begin
            pat <= (load_val == 16'h0000) ? 16'h0001 : load_val;
        end else if (rotate) begin
            pat <= {pat[14:0], pat[15]};
        end
    end

    assign pat0 = pat[0];

endmodule

// File: rtl/dcl_stat_sink.sv
// Destination-side packet sink with throttled ready and saturating statistics.
// Optional io_max_latency output is enabled by defining DCL_SINK_MAXLAT_EN.
module dcl_stat_sink
    import dcl_mab_pkg::*;
#(
    parameter int PORT_ID = 0,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TS_W    = DEF_TS_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_enable,
    input  logic              io_clear,
    input  logic [15:0]       io_dst_pat,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [ADDR_W-1:0] io_in_dst,
    input  logic [TS_W-1:0]   io_in_ts,
    input  logic [DATA_W-1:0] io_in_data,
    input  logic [TS_W-1:0]   io_now,
    output logic [CNT_W-1:0]  io_pkt_count,
    output logic [CNT_W-1:0]  io_cum_latency,
    output logic [CNT_W-1:0]  io_cum_delay,
    output sink_state_t       io_state,
    output logic              io_addr_error
`ifdef DCL_SINK_MAXLAT_EN
    ,
    output logic [TS_W-1:0]   io_max_latency
`endif
);

    // Handshake: a packet transfers in any cycle where io_in_valid and io_in_ready
    // are both high; ready never depends on valid, only on FSM state and pattern.
    sink_state_t     state;
    logic            pat0;
    logic            accept;
    logic            stall;
    logic [TS_W-1:0] latency;
    logic            unused_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (io_enable) state <= LOAD;
                LOAD:    state <= RUN;
                RUN:     if (!io_enable) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dcl_pat_rotator u_pat_rotator (
        .clock    (clock),
        .reset    (reset),
        .load     (state == LOAD),
        .rotate   (state == RUN),
        .load_val (io_dst_pat),
        .pat0     (pat0)
    );

    assign io_in_ready = (state == RUN) & pat0;
    assign io_state    = state;
    assign accept      = io_in_valid & io_in_ready;
    assign stall       = (state == RUN) & io_in_valid & ~pat0;
    // Modulo subtraction absorbs wrap of the shared cycle counter.
    assign latency     = io_now - io_in_ts;
    assign unused_data = ^io_in_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_pkt_count   <= '0;
            io_cum_latency <= '0;
            io_cum_delay   <= '0;
            io_addr_error  <= 1'b0;
        end else if (io_clear) begin
            io_pkt_count   <= '0;
            io_cum_latency <= '0;
            io_cum_delay   <= '0;
            io_addr_error  <= 1'b0;
        end else begin
            if (accept) begin
                io_pkt_count   <= CNT_W'(sat_add(SAT_W'(io_pkt_count), SAT_W'(1), CNT_W));
                io_cum_latency <= CNT_W'(sat_add(SAT_W'(io_cum_latency), SAT_W'(latency), CNT_W));
                if (io_in_dst != ADDR_W'(PORT_ID)) begin
                    io_addr_error <= 1'b1;
                end
            end
            if (stall) begin
                io_cum_delay <= CNT_W'(sat_add(SAT_W'(io_cum_delay), SAT_W'(1), CNT_W));
            end
        end
    end

`ifdef DCL_SINK_MAXLAT_EN
    // A clear coinciding with an accept restarts the maximum from that packet.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_max_latency <= '0;
        end else if (io_clear) begin
            io_max_latency <= accept ? latency : '0;
        end else if (accept && (latency > io_max_latency)) begin
            io_max_latency <= latency;
        end
    end
`endif

endmodule

// File: doc/dcl_stat_sink.md
Name: dcl_stat_sink

Overview:
- Destination-side packet sink and statistics collector; one instance per arbiter output port, directly downstream of the multi-input arbiter.
- Consumes packets over a valid/ready handshake and throttles ready with a rotating 16-bit backpressure pattern.
- Checks each packet's destination address against its own port ID.
- Accumulates packet count, cumulative latency (arrival minus injection timestamp) and cumulative stall cycles; flags misrouted packets.

Parameters:
- PORT_ID, 0, destination address this sink owns.
- ADDR_W, 3, destination address width.
- TS_W, 16, timestamp width; latency arithmetic is modulo 2^TS_W.
- DATA_W, 8, payload width (carried, not checked).
- CNT_W, 32, width of every statistics counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_enable  in  1  run gate; 0 holds ready low and freezes the pattern.
- io_clear  in  1  synchronous clear of all statistics and the error flag.
- io_dst_pat  in  16  backpressure pattern; sampled when not running.
- io_in_valid  in  1  packet valid from arbiter.
- io_in_ready  out  1  sink accepts this cycle.
- io_in_dst  in  ADDR_W  packet destination address.
- io_in_ts  in  TS_W  injection timestamp (source cycle count).
- io_in_data  in  DATA_W  payload.
- io_now  in  TS_W  global free-running cycle count, shared with the sources.
- io_pkt_count  out  CNT_W  accepted packets.
- io_cum_latency  out  CNT_W  sum of per-packet latencies.
- io_cum_delay  out  CNT_W  cycles with valid=1 and ready=0 while running.
- io_addr_error  out  1  sticky; set when a packet with dst != PORT_ID is accepted.

Behaviour:
- Reset: all counters 0; io_addr_error 0; io_in_ready 0; pattern register 16'h0001; FSM in IDLE.
- FSM states and transitions:
  - IDLE -> LOAD when io_enable=1.
  - LOAD (1 cycle): pattern register <= io_dst_pat, or 16'h0001 if io_dst_pat==0. -> RUN.
  - RUN -> IDLE when io_enable=0.
- Ready:
  - In RUN, io_in_ready = pat[0], driven from a register (not combinational from io_in_valid).
  - In IDLE and LOAD, io_in_ready = 0.
- Pattern: in RUN it rotates left by 1 every cycle, regardless of handshake. Leaving RUN freezes it; re-entry reloads it through LOAD.
- Accept = io_in_valid & io_in_ready. On accept:
  - pkt_count += 1.
  - cum_latency += zero-extended (io_now - io_in_ts) mod 2^TS_W.
  - If io_in_dst != PORT_ID, set io_addr_error. The packet is still counted.
- Stall: in RUN, each cycle with io_in_valid=1 and io_in_ready=0 adds 1 to cum_delay. No stall counting outside RUN.
- Counters saturate at all-ones; no wrap.
- Timestamp wrap: io_now < io_in_ts is handled by the modulo subtraction (e.g. now=0x0002, ts=0xFFFE -> latency 4).
- io_clear: synchronous, highest priority over same-cycle updates. Zeroes the counters and the error flag. FSM state and pattern are unaffected.
- Statistics outputs are registered; an update is visible the cycle after the accept.
- Reset asserted mid-packet: everything returns to reset values immediately; an in-flight packet is dropped and not counted.
- Sink never holds data; there is no buffering.

Optional Feature:
- Macro: DCL_SINK_MAXLAT_EN.
- Defined:
  - Adds output io_max_latency (TS_W), reset 0, cleared by io_clear.
  - Updated on accept to max(current, this latency).
  - In the clear-plus-accept cycle it loads that accept's latency.
- Undefined: port and register absent; the other behaviour is identical.

Decomposition:
- Package dcl_mab_pkg holds:
  - the FSM state enum (IDLE, LOAD, RUN);
  - the default widths ADDR_W, TS_W, CNT_W;
  - a packed packet struct {dst, ts, data} shared with the source generator and arbiter.
- One sub-module, dcl_pat_rotator, contains the 16-bit pattern register with load/zero-substitute/rotate/hold and exposes pat[0].
- The saturating add is a function in the package.

Test Plan:
- Pattern 16'hFFFF, PORT_ID=2, valid held high with dst=2 and ts=now-5 for 20 RUN cycles -> pkt_count=20, cum_latency=100, cum_delay=0, addr_error=0.
- Pattern 16'h5555, valid continuously for 16 RUN cycles -> ready alternates 1/0 and pkt_count=8, cum_delay=8.
- One packet with dst=5 to PORT_ID=2 -> addr_error=1 next cycle, pkt_count increments. The flag stays set until io_clear, then reads 0.
- Timestamp wrap, now=0x0003 and ts=0xFFFD -> cum_latency increases by 6. With DCL_SINK_MAXLAT_EN, io_max_latency=6.
- io_dst_pat=0 then enable -> pattern loads 16'h0001, ready high 1 of every 16 cycles. Dropping io_enable -> ready 0 next cycle and cum_delay frozen.
- Reset asserted mid-run with counters nonzero -> all outputs 0 asynchronously. After deassert, enable gives 1 LOAD cycle before the first ready.
